// File: rtl/axis_uart_tx_pkg.sv
// Shared definitions for the AXI-Stream to UART transmitter.
//   tx_state_t : serializer FSM states
//   PAR_*      : parity mode encodings for the PARITY parameter
//   frame_bits : number of bit-times in one UART frame
package axis_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // start + 8 data + optional parity + stop bits
  function automatic int unsigned frame_bits(input int unsigned parity,
                                             input int unsigned stop_bits);
    return 9 + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/axis_uart_tx_baud_tick.sv
// Bit-time generator for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and emits a one-cycle tick on the terminal count,
// so ticks are CLKS_PER_BIT cycles apart. i_clr restarts the count at 0.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   i_clr  : restart the bit-time from count 0
//   o_tick : high for one cycle at the end of each bit-time
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned    CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign o_tick = (cnt == TERMINAL);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-Stream byte sink that serializes each accepted byte onto a UART line,
// LSB first, with optional parity and one or two stop bits. A one-cycle
// o_pkt_done pulse marks the end of the frame of a byte accepted with i_last.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst      : synchronous active-high reset
//   i_data     : stream byte
//   i_last     : byte is the last of its packet
//   i_valid    : stream valid
//   o_ready    : stream ready (high only while idle)
//   o_tx       : registered UART serial output, idle high
//   o_pkt_done : end-of-frame pulse for a last byte
module axis_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_last,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_pkt_done
);

  import axis_uart_tx_pkg::*;

  localparam logic [2:0] DATA_LAST = 3'd7;
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam bit         HAS_PAR   = (PARITY != PAR_NONE);
  localparam bit         ODD_PAR   = (PARITY == PAR_ODD);

  tx_state_t  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       last_q, last_d;
  logic       par_q, par_d;
  logic       tx_d;
  logic       done_d;
  logic       accept;
  logic       tick;

  // Ready comes from registered state only; no path from i_valid.
  assign o_ready = (state_q == ST_IDLE);
  assign accept  = i_valid && o_ready;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (accept),
    .o_tick(tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    last_d    = last_q;
    par_d     = par_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d   = i_data;
          last_d    = i_last;
          par_d     = 1'b0;
          bit_idx_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          par_d   = par_q ^ shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
            state_d   = HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = '0;
            state_d   = ST_IDLE;
            done_d    = last_q;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Line level is decoded from the next state so the registered o_tx
    // changes on the same edge as the state register.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = ODD_PAR ? ~par_d : par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      last_q     <= 1'b0;
      par_q      <= 1'b0;
      o_tx       <= 1'b1;
      o_pkt_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      last_q     <= last_d;
      par_q      <= par_d;
      o_tx       <= tx_d;
      o_pkt_done <= done_d;
    end
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Scoreboard bench for axis_uart_tx. Four instances cover no parity, even
// parity, odd parity and two stop bits, all at 4 clocks per bit. Each accepted
// byte pushes its hand-written serial bit string; a per-instance monitor pops
// it when o_ready drops and checks the line cycle by cycle.
`timescale 1ns/1ps
module tb_axis_uart_tx;

  localparam int CPB = 4;
  localparam int N   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data  [N];
  logic       last  [N];
  logic       valid [N];
  logic       ready [N];
  logic       tx    [N];
  logic       done  [N];

  string sb_bits [N][$];
  bit    sb_last [N][$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  axis_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_data(data[0]), .i_last(last[0]), .i_valid(valid[0]),
    .o_ready(ready[0]), .o_tx(tx[0]), .o_pkt_done(done[0]));

  axis_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_data(data[1]), .i_last(last[1]), .i_valid(valid[1]),
    .o_ready(ready[1]), .o_tx(tx[1]), .o_pkt_done(done[1]));

  axis_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_data(data[2]), .i_last(last[2]), .i_valid(valid[2]),
    .o_ready(ready[2]), .o_tx(tx[2]), .o_pkt_done(done[2]));

  axis_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_data(data[3]), .i_last(last[3]), .i_valid(valid[3]),
    .o_ready(ready[3]), .o_tx(tx[3]), .o_pkt_done(done[3]));

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitors: one per instance, sampling on the falling edge.
  for (genvar g = 0; g < N; g++) begin : g_mon
    int    pos = -1;
    string cur;
    bit    cur_last;
    bit    post_rst = 1'b0;

    always @(negedge clk) begin
      if (rst) begin
        pos      = -1;
        post_rst = 1'b1;
      end else if (post_rst) begin
        chk($sformatf("u%0d after-reset tx", g), tx[g], 1);
        chk($sformatf("u%0d after-reset ready", g), ready[g], 1);
        chk($sformatf("u%0d after-reset pkt_done", g), done[g], 0);
        post_rst = 1'b0;
      end else begin
        if (pos < 0 && ready[g] === 1'b0) begin
          if (sb_bits[g].size() == 0) begin
            chk($sformatf("u%0d ready dropped with no byte offered", g), ready[g], 1);
          end else begin
            cur      = sb_bits[g].pop_front();
            cur_last = sb_last[g].pop_front();
            pos      = 0;
          end
        end
        if (pos < 0) begin
          chk($sformatf("u%0d idle tx", g), tx[g], 1);
          chk($sformatf("u%0d idle pkt_done", g), done[g], 0);
        end else if (pos < cur.len() * CPB) begin
          chk($sformatf("u%0d frame %s cycle %0d tx", g, cur, pos), tx[g],
              (cur.getc(pos / CPB) == "1") ? 1 : 0);
          chk($sformatf("u%0d frame %s cycle %0d ready", g, cur, pos), ready[g], 0);
          chk($sformatf("u%0d frame %s cycle %0d pkt_done", g, cur, pos), done[g], 0);
          pos++;
        end else begin
          chk($sformatf("u%0d frame %s end ready", g, cur), ready[g], 1);
          chk($sformatf("u%0d frame %s end pkt_done", g, cur), done[g], cur_last);
          chk($sformatf("u%0d frame %s end tx", g, cur), tx[g], 1);
          pos = -1;
        end
      end
    end
  end

  // Offer a byte; junk is driven on data/last while the DUT is busy.
  task automatic send(input int i, input logic [7:0] d, input logic l,
                      input string exp_bits, input bit hold, output int acc_cyc);
    int guard = 0;
    valid[i] = 1'b1;
    while (ready[i] !== 1'b1 && guard < 200) begin
      data[i] = 8'($urandom);
      last[i] = 1'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    chk($sformatf("u%0d ready before accept", i), ready[i], 1);
    data[i] = d;
    last[i] = l;
    sb_bits[i].push_back(exp_bits);
    sb_last[i].push_back(l);
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!hold) begin
      valid[i] = 1'b0;
      data[i]  = 8'($urandom);
      last[i]  = 1'($urandom);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, a1, dummy, wait_n;
    for (int i = 0; i < N; i++) begin
      valid[i] = 1'b0;
      data[i]  = '0;
      last[i]  = 1'b0;
    end
    rst = 1'b1;
    gap(3);
    rst = 1'b0;

    // idle line with no traffic
    gap(100);

    // single byte 'a'
    send(0, 8'h61, 1'b1, "0100001101", 1'b0, dummy);
    gap(50);

    // two-byte packet "aa" with valid held high
    send(0, 8'h61, 1'b0, "0100001101", 1'b1, a0);
    send(0, 8'h61, 1'b1, "0100001101", 1'b0, a1);
    chk("u0 second accept spacing", a1 - a0, 41);
    wait_n = 0;
    while (done[0] !== 1'b1 && wait_n < 100) begin
      @(posedge clk); #1;
      wait_n++;
    end
    chk("u0 pkt_done cycle after first accept", cyc - a0, 81);
    gap(10);

    // all-zero and all-one bytes
    send(0, 8'h00, 1'b0, "0000000001", 1'b0, dummy);
    send(0, 8'hFF, 1'b1, "0111111111", 1'b0, dummy);
    gap(50);

    // even parity
    send(1, 8'h61, 1'b1, "01000011011", 1'b0, dummy);
    send(1, 8'h00, 1'b1, "00000000001", 1'b0, dummy);
    gap(50);

    // odd parity
    send(2, 8'h61, 1'b1, "01000011001", 1'b0, dummy);
    send(2, 8'hFF, 1'b1, "01111111111", 1'b0, dummy);
    gap(50);

    // two stop bits
    send(3, 8'hA5, 1'b0, "01010010111", 1'b0, dummy);
    send(3, 8'h0F, 1'b1, "01111000011", 1'b0, dummy);
    gap(50);

    // reset during data bit 3, then a clean byte
    send(0, 8'h61, 1'b1, "0100001101", 1'b0, dummy);
    gap(17);
    rst = 1'b1;
    gap(1);
    rst = 1'b0;
    gap(5);
    send(0, 8'h0F, 1'b1, "0111100001", 1'b0, dummy);
    gap(60);

    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d leftover expected frames", i), sb_bits[i].size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
